// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill: one critical-word-first AHB-Lite WRAP4 read per miss,
// early forwarding of the missed word, and a single write of the assembled 128-bit line.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for miss_req; bus idle
// S_BURST | WRAP4 in flight: address and data phases overlap
// S_DONE  | one cycle: line written into the entry array
// S_ERR   | one cycle: refill_err pulsed, partial line dropped
module icache_refill_ctrl #(
  parameter int CACHE_SIZE = 8192,
  parameter int CACHE_LINE = 128,
  parameter int INDEX_W    = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
  parameter int TAG_W      = 32 - 4 - INDEX_W
) (
  input  logic               hclk,
  input  logic               hrst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  output logic               busy,
  output logic               crit_valid,
  output logic [31:0]        crit_data,
  output logic               line_we,
  output logic [INDEX_W-1:0] line_index,
  output logic [TAG_W-1:0]   line_tag,
  output logic [127:0]       line_data,
  output logic               line_valid,
  output logic               refill_done,
  output logic               refill_err,
  output logic [31:0]        m_haddr,
  output logic [1:0]         m_htrans,
  output logic [2:0]         m_hburst,
  output logic [2:0]         m_hsize,
  output logic               m_hwrite,
  input  logic [31:0]        m_hrdata,
  input  logic               m_hready,
  input  logic               m_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE, S_ERR} state_t;

  state_t      state;
  logic [27:0] base_hi;
  logic [1:0]  crit;
  logic [2:0]  addr_cnt;
  logic [2:0]  data_cnt;
  logic [1:0]  next_slot;
  logic [1:0]  wr_slot;
  logic        addr_accept;
  logic        data_pending;
  logic        unused_addr_bits;

  assign m_hburst = 3'b010;
  assign m_hsize  = 3'b010;
  assign m_hwrite = 1'b0;

  // Word slots wrap within the line, starting from the missed word.
  assign next_slot    = crit + addr_cnt[1:0] + 2'd1;
  assign wr_slot      = crit + data_cnt[1:0];
  assign addr_accept  = m_hready && (m_htrans != HTRANS_IDLE);
  assign data_pending = (data_cnt < addr_cnt);

  assign unused_addr_bits = ^miss_addr[1:0];

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state       <= S_IDLE;
      base_hi     <= '0;
      crit        <= '0;
      addr_cnt    <= '0;
      data_cnt    <= '0;
      busy        <= 1'b0;
      crit_valid  <= 1'b0;
      crit_data   <= '0;
      line_we     <= 1'b0;
      line_valid  <= 1'b0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
      line_index  <= '0;
      line_tag    <= '0;
      line_data   <= '0;
      m_haddr     <= '0;
      m_htrans    <= HTRANS_IDLE;
    end else begin
      crit_valid  <= 1'b0;
      line_we     <= 1'b0;
      line_valid  <= 1'b0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (miss_req) begin
            base_hi    <= miss_addr[31:4];
            crit       <= miss_addr[3:2];
            line_index <= miss_addr[INDEX_W+3:4];
            line_tag   <= miss_addr[31:INDEX_W+4];
            m_haddr    <= {miss_addr[31:2], 2'b00};
            m_htrans   <= HTRANS_NONSEQ;
            addr_cnt   <= '0;
            data_cnt   <= '0;
            busy       <= 1'b1;
            state      <= S_BURST;
          end
        end

        S_BURST: begin
          if (m_hresp && m_hready) begin
            m_htrans   <= HTRANS_IDLE;
            refill_err <= 1'b1;
            state      <= S_ERR;
          end else if (m_hresp) begin
            // First error cycle: cancel the pending address so nothing more is issued.
            m_htrans <= HTRANS_IDLE;
          end else if (m_hready) begin
            if (addr_accept) begin
              addr_cnt <= addr_cnt + 3'd1;
              if (addr_cnt < 3'd3) begin
                m_haddr  <= {base_hi, next_slot, 2'b00};
                m_htrans <= HTRANS_SEQ;
              end else begin
                m_htrans <= HTRANS_IDLE;
              end
            end
            if (data_pending) begin
              line_data[{wr_slot, 5'd0} +: 32] <= m_hrdata;
              data_cnt <= data_cnt + 3'd1;
              if (data_cnt == 3'd0) begin
                crit_data  <= m_hrdata;
                crit_valid <= 1'b1;
              end
              if (data_cnt == 3'd3) begin
                line_we     <= 1'b1;
                line_valid  <= 1'b1;
                refill_done <= 1'b1;
                state       <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed refill scenarios against a cycle-timeline model built from the AHB pipeline
// rules (ready edges), plus literal pins on addresses, line contents and latencies.
module tb_icache_refill_ctrl;

  logic         hclk, hrst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy, crit_valid, line_we, line_valid, refill_done, refill_err;
  logic [31:0]  crit_data;
  logic [8:0]   line_index;
  logic [18:0]  line_tag;
  logic [127:0] line_data;
  logic [31:0]  m_haddr, m_hrdata;
  logic [1:0]   m_htrans;
  logic [2:0]   m_hburst, m_hsize;
  logic         m_hwrite, m_hready, m_hresp;

  icache_refill_ctrl dut (
    .hclk(hclk), .hrst(hrst), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .crit_valid(crit_valid), .crit_data(crit_data),
    .line_we(line_we), .line_index(line_index), .line_tag(line_tag),
    .line_data(line_data), .line_valid(line_valid), .refill_done(refill_done),
    .refill_err(refill_err), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hburst(m_hburst), .m_hsize(m_hsize), .m_hwrite(m_hwrite),
    .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Expected timeline, indexed by cycle k after the accept edge (cycle k ends at edge k).
  logic         exp_busy  [0:39];
  logic [1:0]   exp_trans [0:39];
  logic [31:0]  exp_addr  [0:39];
  logic         exp_cv    [0:39];
  logic         exp_we    [0:39];
  logic         exp_err   [0:39];
  logic [127:0] exp_line;
  logic [31:0]  exp_crit;
  logic [8:0]   exp_index;
  logic [18:0]  exp_tag;
  bit           active = 0;
  int           cyc = 0;

  int           clk_cnt = 0;
  always @(posedge hclk) clk_cnt++;

  // Observations kept for the literal pins.
  int           seen_we_cyc, seen_err_cyc, prev_start, cur_start;
  logic [127:0] seen_line;
  logic [31:0]  seen_crit;
  logic [31:0]  addr_q[$];

  always @(negedge hclk) begin
    if (active) begin
      if (cyc == 1) begin
        seen_we_cyc  = 0;
        seen_err_cyc = 0;
        addr_q.delete();
        prev_start = cur_start;
        cur_start  = clk_cnt;
      end
      chk("busy",        busy,        exp_busy[cyc]);
      chk("htrans",      m_htrans,    exp_trans[cyc]);
      if (exp_trans[cyc] != 2'b00) chk("haddr", m_haddr, exp_addr[cyc]);
      chk("crit_valid",  crit_valid,  exp_cv[cyc]);
      chk("line_we",     line_we,     exp_we[cyc]);
      chk("line_valid",  line_valid,  exp_we[cyc]);
      chk("refill_done", refill_done, exp_we[cyc]);
      chk("refill_err",  refill_err,  exp_err[cyc]);
      if (exp_cv[cyc]) chk("crit_data", crit_data, exp_crit);
      if (exp_we[cyc]) begin
        chk("line_data",  line_data,  exp_line);
        chk("line_index", line_index, exp_index);
        chk("line_tag",   line_tag,   exp_tag);
      end
      if (m_hready && m_htrans != 2'b00) addr_q.push_back(m_haddr);
      if (line_we) begin seen_we_cyc = cyc; seen_line = line_data; end
      if (crit_valid) seen_crit = crit_data;
      if (refill_err) seen_err_cyc = cyc;
    end
  end

  task automatic run_refill(input logic [31:0] a, input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input int wait_edge,
                            input int n_wait, input int err_edge, input bit hold);
    logic        rdy [0:39];
    logic        rsp [0:39];
    logic [31:0] dat [0:39];
    logic [31:0] bt  [0:3];
    int r[0:9];
    int nr, last, lo, s;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    for (int e = 0; e < 40; e++) begin
      rdy[e] = 1'b1; rsp[e] = 1'b0; dat[e] = 32'hDEAD_0000 | e;
    end
    for (int e = wait_edge; e < wait_edge + n_wait; e++) rdy[e] = 1'b0;
    if (err_edge > 0) begin
      rdy[err_edge] = 1'b0; rsp[err_edge] = 1'b1; rsp[err_edge+1] = 1'b1;
    end
    nr = 0;
    for (int e = 1; e < 40; e++) if (rdy[e] && nr < 10) begin r[nr] = e; nr++; end
    // Address j completes at ready edge r[j]; its data completes at the next ready edge r[j+1].
    for (int m = 1; m <= 4; m++)
      if (err_edge == 0 || r[m] < err_edge) dat[r[m]] = bt[m-1];
    last = (err_edge > 0) ? err_edge + 3 : r[4] + 2;
    exp_line = '0;
    for (int j = 0; j < 4; j++) begin
      s = (int'(a[3:2]) + j) % 4;
      exp_line[s*32 +: 32] = bt[j];
    end
    exp_crit  = b0;
    exp_index = a[12:4];
    exp_tag   = a[31:13];
    for (int k = 0; k < 40; k++) begin
      exp_busy[k]  = (k >= 1 && k < last);
      exp_trans[k] = 2'b00;
      exp_addr[k]  = '0;
      for (int j = 0; j < 4; j++) begin
        lo = (j == 0) ? 0 : r[j-1];
        if (k > lo && k <= r[j]) begin
          exp_trans[k] = (j == 0) ? 2'b10 : 2'b11;
          exp_addr[k]  = {a[31:4], 4'b0} + 32'((int'(a[3:2]) + j) % 4 * 4);
        end
      end
      if (err_edge > 0 && k > err_edge) exp_trans[k] = 2'b00;
      exp_cv[k]  = (k == r[1] + 1) && (err_edge == 0 || r[1] < err_edge);
      exp_we[k]  = (err_edge == 0) && (k == r[4] + 1);
      exp_err[k] = (err_edge > 0) && (k == err_edge + 2);
    end

    miss_addr = a;
    miss_req  = 1'b1;
    @(posedge hclk);
    #1;
    if (!hold) miss_req = 1'b0;
    active = 1;
    for (int k = 1; k <= last; k++) begin
      cyc      = k;
      m_hready = rdy[k];
      m_hresp  = rsp[k];
      m_hrdata = dat[k];
      @(negedge hclk);
      #1;
      if (k < last) begin
        @(posedge hclk);
        #1;
      end
    end
    active   = 0;
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
  endtask

  initial begin
    hrst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    m_hready = 1'b1; m_hresp = 1'b0; m_hrdata = '0;
    prev_start = 0; cur_start = 0; seen_we_cyc = 0; seen_err_cyc = 0;
    seen_line = '0; seen_crit = '0;

    @(negedge hclk);
    chk("rst_busy",   busy,      1'b0);
    chk("rst_htrans", m_htrans,  2'b00);
    chk("rst_haddr",  m_haddr,   32'h0);
    chk("rst_we",     line_we,   1'b0);
    chk("rst_line",   line_data, 128'h0);
    chk("hburst",     m_hburst,  3'b010);
    chk("hsize",      m_hsize,   3'b010);
    chk("hwrite",     m_hwrite,  1'b0);
    @(negedge hclk);
    hrst = 1'b0;
    @(negedge hclk);

    // Zero-wait, critical word in slot 2.
    run_refill(32'h0000_1238, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 0, 0);
    chk("t1_naddr", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("t1_a0", addr_q[0], 32'h1238);
      chk("t1_a1", addr_q[1], 32'h123C);
      chk("t1_a2", addr_q[2], 32'h1230);
      chk("t1_a3", addr_q[3], 32'h1234);
    end
    chk("t1_line", seen_line, 128'h0000000B_0000000A_0000000D_0000000C);
    chk("t1_crit", seen_crit, 32'hA);
    chk("t1_we_cyc", seen_we_cyc, 6);

    // Aligned miss: beats land in order.
    run_refill(32'h0000_0040, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0);
    if (addr_q.size() == 4) begin
      chk("t2_a0", addr_q[0], 32'h40);
      chk("t2_a3", addr_q[3], 32'h4C);
    end else chk("t2_naddr", addr_q.size(), 4);
    chk("t2_line", seen_line, 128'h00000044_00000033_00000022_00000011);

    // Two wait states on the second data beat.
    run_refill(32'h0000_2A74, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 3, 2, 0, 0);
    chk("t3_we_cyc", seen_we_cyc, 8);

    // ERROR on the third beat, then a normal wrap-at-top-of-line refill.
    run_refill(32'h0000_0100, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 4, 0);
    chk("t4_err_cyc", seen_err_cyc, 6);
    chk("t4_no_we",   seen_we_cyc, 0);
    run_refill(32'h0000_3FFC, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 0, 0, 0, 0);
    chk("t4b_line", seen_line, 128'hC0DE0000_C0DE0003_C0DE0002_C0DE0001);

    // Reset after the first data beat.
    miss_addr = 32'h0000_0500; miss_req = 1'b1;
    @(posedge hclk); #1;
    miss_req = 1'b0; m_hrdata = 32'hDEAD_BEEF;
    @(posedge hclk); #1;
    m_hrdata = 32'h55;
    @(posedge hclk); #1;
    m_hrdata = 32'h66;
    chk("t5_cv_before", crit_valid, 1'b1);
    #2 hrst = 1'b1;
    #1;
    chk("t5_busy",   busy,       1'b0);
    chk("t5_htrans", m_htrans,   2'b00);
    chk("t5_haddr",  m_haddr,    32'h0);
    chk("t5_cv",     crit_valid, 1'b0);
    chk("t5_crit",   crit_data,  32'h0);
    chk("t5_line",   line_data,  128'h0);
    chk("t5_index",  line_index, 9'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      chk("t5_we_in_rst", line_we, 1'b0);
    end
    hrst = 1'b0;
    m_hrdata = '0;
    @(negedge hclk);
    run_refill(32'h0000_0504, 32'h9, 32'hA, 32'hB, 32'hC, 0, 0, 0, 0);
    chk("t5_line_after", seen_line, 128'h0000000B_0000000A_00000009_0000000C);

    // miss_req held: back-to-back refills, 7 cycles apart.
    run_refill(32'h0000_0808, 32'h21, 32'h22, 32'h23, 32'h24, 0, 0, 0, 1);
    run_refill(32'h0000_0808, 32'h31, 32'h32, 32'h33, 32'h34, 0, 0, 0, 0);
    chk("t6_spacing", cur_start - prev_start, 7);
    @(negedge hclk);
    chk("t6_idle_after", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
